// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, synchronous
// flush, bubble control-word substitution and saturating stall/bubble counters.
//
//   state   | meaning
//   S_EMPTY | no entry held, outputs show the bubble word
//   S_ONE   | main register holds the head entry
//   S_FULL  | main holds the head, skid holds the next entry, in_ready low
module pipe_skid_stage #(
    parameter int           DATA_W     = 64,
    parameter int           SIG_W      = 32,
    parameter logic [SIG_W-1:0] BUBBLE_SIG = 32'h80000000,
    parameter int           CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIG_W-1:0]  in_signal,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIG_W-1:0]  out_signal,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [SIG_W-1:0]  main_sig;
    logic [DATA_W-1:0] skid_data;
    logic [SIG_W-1:0]  skid_sig;

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_sig  <= '0;
            skid_data <= '0;
            skid_sig  <= '0;
        end else if (flush) begin
            // An entry accepted in the flush cycle is dropped along with the rest.
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_sig  <= in_signal;
                        state     <= S_ONE;
                        out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        main_data <= in_data;
                        main_sig  <= in_signal;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_sig  <= in_signal;
                        state     <= S_FULL;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        state     <= S_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_sig  <= skid_sig;
                        state     <= S_ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data   = main_data;
    assign out_signal = out_valid ? main_sig : BUBBLE_SIG;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
